// File: rtl/param_sequence_detector.sv
// param_sequence_detector: serial bit-pattern detector that can be reprogrammed at runtime.
// The pattern (1..PAT_W bits), its length and the overlap mode are loadable.
// Outputs are a Mealy match pulse and a copy of it registered one cycle later.
// Optional feature macro: SEQ_DET_MATCH_CNT_EN adds the saturating match_cnt output.
module param_sequence_detector #(
   parameter int unsigned          PAT_W       = 4,
   parameter logic [PAT_W-1:0]     DEF_PATTERN = 4'b1011,
   parameter int unsigned          DEF_LEN     = 4,
   parameter bit                   DEF_OVERLAP = 1'b1,
   parameter int unsigned          CNT_W       = 8,
   localparam int unsigned         LEN_W       = $clog2(PAT_W + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    in_valid,
   input  logic                    in,
   input  logic                    cfg_we,
   input  logic [PAT_W-1:0]        cfg_pattern,
   input  logic [LEN_W-1:0]        cfg_len,
   input  logic                    cfg_overlap,
   output logic                    match,
   output logic                    match_q
`ifdef SEQ_DET_MATCH_CNT_EN
   ,
   output logic [CNT_W-1:0]        match_cnt
`endif
);

   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
   localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);
   localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

   typedef enum logic [1:0] {StIdle, StFill, StRun} state_t;

   state_t               state_q;
   logic [PAT_W-1:0]     pattern_q;
   logic [LEN_W-1:0]     len_q;
   logic                 overlap_q;
   logic [PAT_W-2:0]     hist_q;
   logic [LEN_W-1:0]     fill_q;

   logic                 accepted;
   logic [PAT_W-1:0]     window;
   logic [PAT_W-1:0]     mask;
   logic                 hit;
   logic [LEN_W-1:0]     fill_inc;
   logic [LEN_W-1:0]     cfg_len_eff;
   state_t               restart_state;

   // Qualify the input bit, build the compare window and length mask, and decide match.
   always_comb begin
      accepted = in_valid & en & ~cfg_we;
      window   = {hist_q, in};
      mask     = '0;
      for (int i = 0; i < int'(PAT_W); i++) begin
         mask[i] = (i < int'(len_q));
      end
      hit      = (((window ^ pattern_q) & mask) == '0);
      match    = (state_q == StRun) && accepted && hit;
      fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + ONE;
      // A length of zero, or one above PAT_W, falls back to the full width.
      cfg_len_eff   = ((cfg_len == '0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;
      // A 1-bit pattern has no history to fill, so the detector restarts straight in RUN.
      restart_state = (len_q == ONE) ? StRun : StFill;
   end

   // Detector FSM together with the configuration, history and registered match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         pattern_q <= DEF_PATTERN;
         len_q     <= LEN_W'(DEF_LEN);
         overlap_q <= DEF_OVERLAP;
         hist_q    <= '0;
         fill_q    <= '0;
         match_q   <= 1'b0;
      end else begin
         match_q <= match;
         if (cfg_we) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len_eff;
            overlap_q <= cfg_overlap;
            hist_q    <= '0;
            fill_q    <= '0;
            if (!en) begin
               state_q <= StIdle;
            end else begin
               state_q <= (cfg_len_eff == ONE) ? StRun : StFill;
            end
         end else if (!en) begin
            state_q <= StIdle;
            hist_q  <= '0;
            fill_q  <= '0;
         end else if (accepted) begin
            if (match && !overlap_q) begin
               // The matching bit is consumed and does not seed the next match.
               hist_q  <= '0;
               fill_q  <= '0;
               state_q <= restart_state;
            end else begin
               hist_q  <= window[PAT_W-2:0];
               fill_q  <= fill_inc;
               state_q <= (fill_inc >= (len_q - ONE)) ? StRun : StFill;
            end
         end else if (state_q == StIdle) begin
            state_q <= restart_state;
         end
      end
   end

`ifdef SEQ_DET_MATCH_CNT_EN
   // Saturating match counter. Reconfiguration clears it; disabling does not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         match_cnt <= '0;
      end else if (cfg_we) begin
         match_cnt <= '0;
      end else if (match && (match_cnt != {CNT_W{1'b1}})) begin
         match_cnt <= match_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed self-checking bench for param_sequence_detector (default parameters).
module tb_param_sequence_detector;

   logic       clk;
   logic       reset;
   logic       en;
   logic       in_valid;
   logic       in;
   logic       cfg_we;
   logic [3:0] cfg_pattern;
   logic [2:0] cfg_len;
   logic       cfg_overlap;
   logic       match;
   logic       match_q;
`ifdef SEQ_DET_MATCH_CNT_EN
   logic [7:0] match_cnt;
`endif

   int total;
   int bad;

   param_sequence_detector dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .in_valid    (in_valid),
      .in          (in),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .match       (match),
      .match_q     (match_q)
`ifdef SEQ_DET_MATCH_CNT_EN
      ,
      .match_cnt   (match_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

   // Drive one cycle; sample match mid-cycle and match_q just after the edge.
   task automatic apply(input logic v, input logic b, output logic m, output logic mq);
      @(negedge clk);
      in_valid = v;
      in       = b;
      #1 m = match;
      @(posedge clk);
      #1 mq = match_q;
   endtask

   task automatic do_reset();
      logic m, mq;
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      apply(1'b0, 1'b0, m, mq);
   endtask

   task automatic do_cfg(input logic [3:0] pat, input logic [2:0] len, input logic ov,
                         input logic v, input logic b, output logic m);
      @(negedge clk);
      cfg_we      = 1'b1;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ov;
      in_valid    = v;
      in          = b;
      #1 m = match;
      @(posedge clk);
      #1;
      cfg_we   = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      en = 1'b1;
      in_valid = 1'b1;
      in = 1'b1;
      #1;
      total++;
      if (match !== 1'b0) begin bad++; $display("FAIL reset_match got %b want 0", match); end
      total++;
      if (match_q !== 1'b0) begin bad++; $display("FAIL reset_match_q got %b want 0", match_q); end
`ifdef SEQ_DET_MATCH_CNT_EN
      total++;
      if (match_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", match_cnt); end
`endif
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [3:0] d = 4'b1011;
      logic [3:0] e = 4'b0001;
      logic m, mq;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, d[3-i], m, mq);
         total++;
         if (m !== e[3-i]) begin bad++; $display("FAIL basic_match bit %0d got %b want %b", i, m, e[3-i]); end
         total++;
         if (mq !== e[3-i]) begin bad++; $display("FAIL basic_match_q bit %0d got %b want %b", i, mq, e[3-i]); end
      end
   endtask

   task automatic test_overlap();
      logic [6:0] d = 7'b1011011;
      logic [6:0] e = 7'b0001001;
      logic m, mq;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, d[6-i], m, mq);
         total++;
         if (m !== e[6-i]) begin bad++; $display("FAIL overlap_match bit %0d got %b want %b", i, m, e[6-i]); end
         total++;
         if (mq !== e[6-i]) begin bad++; $display("FAIL overlap_match_q bit %0d got %b want %b", i, mq, e[6-i]); end
      end
`ifdef SEQ_DET_MATCH_CNT_EN
      total++;
      if (match_cnt !== 8'd2) begin bad++; $display("FAIL overlap_cnt got %0d want 2", match_cnt); end
`endif
   endtask

   task automatic test_no_overlap();
      logic [10:0] d = 11'b10110111011;
      logic [10:0] e = 11'b00010000001;
      logic m, mq;
      do_cfg(4'b1011, 3'd4, 1'b0, 1'b0, 1'b0, m);
`ifdef SEQ_DET_MATCH_CNT_EN
      total++;
      if (match_cnt !== 8'd0) begin bad++; $display("FAIL cfg_clears_cnt got %0d want 0", match_cnt); end
`endif
      for (int i = 0; i < 11; i++) begin
         apply(1'b1, d[10-i], m, mq);
         total++;
         if (m !== e[10-i]) begin bad++; $display("FAIL no_overlap_match bit %0d got %b want %b", i, m, e[10-i]); end
      end
`ifdef SEQ_DET_MATCH_CNT_EN
      total++;
      if (match_cnt !== 8'd2) begin bad++; $display("FAIL no_overlap_cnt got %0d want 2", match_cnt); end
`endif
   endtask

   task automatic test_gaps();
      logic [6:0] v = 7'b1010011;
      logic [6:0] d = 7'b1101111;
      logic [6:0] e = 7'b0000001;
      logic m, mq;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         apply(v[6-i], d[6-i], m, mq);
         total++;
         if (m !== e[6-i]) begin bad++; $display("FAIL gaps_match step %0d got %b want %b", i, m, e[6-i]); end
      end
   endtask

   task automatic test_cfg_midstream();
      logic [3:0] d = 4'b0110;
      logic [3:0] e = 4'b0001;
      logic m, mq;
      do_reset();
      apply(1'b1, 1'b1, m, mq);
      apply(1'b1, 1'b1, m, mq);
      do_cfg(4'b0110, 3'd3, 1'b1, 1'b1, 1'b0, m);
      total++;
      if (m !== 1'b0) begin bad++; $display("FAIL cfg_cycle_match got %b want 0", m); end
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, d[3-i], m, mq);
         total++;
         if (m !== e[3-i]) begin bad++; $display("FAIL cfg_mid_match bit %0d got %b want %b", i, m, e[3-i]); end
      end
   endtask

   task automatic test_en_reset_len1();
      logic [3:0] d = 4'b1011;
      logic [3:0] e = 4'b0001;
      logic m, mq;
      do_reset();
      apply(1'b1, 1'b1, m, mq);
      apply(1'b1, 1'b0, m, mq);
      apply(1'b1, 1'b1, m, mq);
      @(negedge clk);
      en = 1'b0;
      in_valid = 1'b1;
      in = 1'b1;
      #1;
      total++;
      if (match !== 1'b0) begin bad++; $display("FAIL en_low_match got %b want 0", match); end
      @(negedge clk);
      en = 1'b1;
      in_valid = 1'b0;
      // History was cleared, so 1,0,1,1 is needed again from scratch.
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, d[3-i], m, mq);
         total++;
         if (m !== e[3-i]) begin bad++; $display("FAIL after_en_match bit %0d got %b want %b", i, m, e[3-i]); end
      end
      apply(1'b1, 1'b1, m, mq);
      apply(1'b1, 1'b0, m, mq);
      @(negedge clk);
      in_valid = 1'b1;
      in = 1'b1;
      reset = 1'b1;
      #1;
      total++;
      if (match_q !== 1'b0) begin bad++; $display("FAIL midreset_match_q got %b want 0", match_q); end
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      apply(1'b0, 1'b0, m, mq);
      apply(1'b1, 1'b1, m, mq);
      total++;
      if (m !== 1'b0) begin bad++; $display("FAIL after_reset_match got %b want 0", m); end
      // Single-bit pattern '1': every valid 1 matches.
      do_cfg(4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, m);
      e = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, d[3-i], m, mq);
         total++;
         if (m !== e[3-i]) begin bad++; $display("FAIL len1_match bit %0d got %b want %b", i, m, e[3-i]); end
      end
      // Length 0 falls back to the full 4 bits.
      do_cfg(4'b1011, 3'd0, 1'b0, 1'b0, 1'b0, m);
      e = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, d[3-i], m, mq);
         total++;
         if (m !== e[3-i]) begin bad++; $display("FAIL len0_match bit %0d got %b want %b", i, m, e[3-i]); end
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b0;
      en = 1'b0;
      in_valid = 1'b0;
      in = 1'b0;
      cfg_we = 1'b0;
      cfg_pattern = 4'b0000;
      cfg_len = 3'd0;
      cfg_overlap = 1'b0;
      test_reset();
      test_basic();
      test_overlap();
      test_no_overlap();
      test_gaps();
      test_cfg_midstream();
      test_en_reset_len1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
